// File: rtl/line_bus_bridge.sv
// line_bus_bridge: serialises whole-line cache commands into DATA_WIDTH-bit
// memory bursts and returns a one-cycle completion pulse to the cache.
//   clk, reset (sync, active-low)
//   command_*      : one-line command from the cache (valid/store/addr/line)
//   data_from_bus  : assembled read line, stable while bus_valid is high
//   bus_valid      : load-complete pulse;  bus_ready : store-complete pulse
//   mem_req_*      : burst request (valid/ready/store/addr)
//   mem_rdata_*    : read beats in;  mem_wdata_* : write beats out
//   mem_wack_valid : write burst committed
module line_bus_bridge #(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned OFFSET_LENGTH = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     command_valid,
    input  logic                                     command_store,
    input  logic                                     command_rready,
    input  logic [ADDR_WIDTH-1:0]                    command_addr,
    input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_to_bus,
    output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_from_bus,
    output logic                                     bus_valid,
    output logic                                     bus_ready,
    output logic                                     mem_req_valid,
    input  logic                                     mem_req_ready,
    output logic                                     mem_req_store,
    output logic [ADDR_WIDTH-1:0]                    mem_req_addr,
    input  logic                                     mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata,
    output logic                                     mem_wdata_valid,
    input  logic                                     mem_wdata_ready,
    output logic [DATA_WIDTH-1:0]                    mem_wdata,
    output logic                                     mem_wdata_last,
    input  logic                                     mem_wack_valid
);

    localparam int unsigned BEATS = 2 ** OFFSET_LENGTH;
    localparam logic [OFFSET_LENGTH-1:0] LAST_BEAT = OFFSET_LENGTH'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WACK  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [OFFSET_LENGTH-1:0]         cnt;
    logic [OFFSET_LENGTH-1:0]         cnt_next;
    logic [BEATS-1:0][DATA_WIDTH-1:0] rd_line;
    logic [BEATS-1:0][DATA_WIDTH-1:0] wr_line;
    logic                             req_valid_d;
    logic                             wdata_valid_d;
    logic                             wdata_last_d;
    logic [DATA_WIDTH-1:0]            wdata_d;
    logic                             bus_valid_d;
    logic                             bus_ready_d;
    logic                             unused_inputs;

    // command_rready is informational; low address bits are forced to zero
    assign unused_inputs = ^{command_rready, command_addr[OFFSET_LENGTH-1:0]};

    assign data_from_bus = rd_line;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (command_valid) state_next = REQ;
            REQ:     if (mem_req_ready) state_next = mem_req_store ? WDATA : RDATA;
            RDATA:   if (mem_rdata_valid && cnt == LAST_BEAT) state_next = RESP;
            WDATA:   if (mem_wdata_ready && cnt == LAST_BEAT) state_next = WACK;
            WACK:    if (mem_wack_valid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter and look-ahead output values, registered below
    always_comb begin
        cnt_next      = cnt;
        req_valid_d   = 1'b0;
        wdata_valid_d = 1'b0;
        wdata_last_d  = 1'b0;
        wdata_d       = '0;
        bus_valid_d   = 1'b0;
        bus_ready_d   = 1'b0;
        case (state)
            REQ:     if (mem_req_ready) cnt_next = '0;
            RDATA:   if (mem_rdata_valid) cnt_next = cnt + OFFSET_LENGTH'(1);
            WDATA:   if (mem_wdata_ready) cnt_next = cnt + OFFSET_LENGTH'(1);
            default: cnt_next = cnt;
        endcase
        req_valid_d   = (state_next == REQ);
        wdata_valid_d = (state_next == WDATA);
        wdata_last_d  = (state_next == WDATA) && (cnt_next == LAST_BEAT);
        wdata_d       = wr_line[cnt_next];
        bus_valid_d   = (state_next == RESP) && !mem_req_store;
        bus_ready_d   = (state_next == RESP) && mem_req_store;
    end

    // Registered outputs, command latch and read-line assembly
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt             <= '0;
            rd_line         <= '0;
            mem_req_addr    <= '0;
            mem_req_store   <= 1'b0;
            mem_req_valid   <= 1'b0;
            mem_wdata_valid <= 1'b0;
            mem_wdata_last  <= 1'b0;
            mem_wdata       <= '0;
            bus_valid       <= 1'b0;
            bus_ready       <= 1'b0;
        end else begin
            cnt             <= cnt_next;
            mem_req_valid   <= req_valid_d;
            mem_wdata_valid <= wdata_valid_d;
            mem_wdata_last  <= wdata_last_d;
            mem_wdata       <= wdata_d;
            bus_valid       <= bus_valid_d;
            bus_ready       <= bus_ready_d;
            if (state == IDLE && command_valid) begin
                mem_req_addr  <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
                mem_req_store <= command_store;
            end
            if (state == RDATA && mem_rdata_valid) begin
                rd_line[cnt] <= mem_rdata;
            end
        end
    end

    // Write-back line buffer; only ever read after being loaded in IDLE
    always_ff @(posedge clk) begin
        if (state == IDLE && command_valid && command_store) begin
            wr_line <= data_to_bus;
        end
    end

endmodule

// File: tb/tb_line_bus_bridge.sv
`timescale 1ns/1ps
module tb_line_bus_bridge;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BEATS = 16;
    localparam int LW    = DW * BEATS;

    logic          clk = 1'b0;
    logic          reset;
    logic          command_valid;
    logic          command_store;
    logic          command_rready;
    logic [AW-1:0] command_addr;
    logic [LW-1:0] data_to_bus;
    logic [LW-1:0] data_from_bus;
    logic          bus_valid;
    logic          bus_ready;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_store;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rdata_valid;
    logic [DW-1:0] mem_rdata;
    logic          mem_wdata_valid;
    logic          mem_wdata_ready;
    logic [DW-1:0] mem_wdata;
    logic          mem_wdata_last;
    logic          mem_wack_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_bv     = 0;
    int n_br     = 0;

    always #5 clk = ~clk;

    line_bus_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .OFFSET_LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .command_valid(command_valid), .command_store(command_store),
        .command_rready(command_rready), .command_addr(command_addr),
        .data_to_bus(data_to_bus), .data_from_bus(data_from_bus),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
        .mem_wack_valid(mem_wack_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one command, counted beats, a pending pulse flag
    typedef struct packed {
        logic                     busy;
        logic                     store;
        logic                     req_done;
        logic                     pulse;
        logic [5:0]               beats;
        logic [63:0]              addr;
        logic [BEATS-1:0][63:0]   wline;
        logic [BEATS-1:0][63:0]   rline;
    } model_t;

    function automatic model_t model_next(input model_t m, input logic rst_n,
                                          input logic cv, input logic cs,
                                          input logic [63:0] ca, input logic [LW-1:0] cd,
                                          input logic qr, input logic rv, input logic [63:0] rd,
                                          input logic wr, input logic wk);
        model_t nx = m;
        if (!rst_n) return '0;
        if (!m.busy) begin
            if (cv) begin
                nx.busy = 1'b1; nx.store = cs; nx.addr = {ca[63:4], 4'h0};
                nx.req_done = 1'b0; nx.beats = '0; nx.pulse = 1'b0;
                if (cs) nx.wline = cd;
            end
        end else if (m.pulse) begin
            nx.busy = 1'b0; nx.pulse = 1'b0;
        end else if (!m.req_done) begin
            if (qr) begin nx.req_done = 1'b1; nx.beats = '0; end
        end else if (!m.store) begin
            if (rv) begin
                nx.rline[m.beats[3:0]] = rd;
                nx.beats = m.beats + 6'd1;
                if (nx.beats == 6'd16) nx.pulse = 1'b1;
            end
        end else if (m.beats < 6'd16) begin
            if (wr) nx.beats = m.beats + 6'd1;
        end else if (wk) begin
            nx.pulse = 1'b1;
        end
        return nx;
    endfunction

    model_t m = '0;
    bit     model_live = 1'b0;

    always @(posedge clk) begin
        m <= model_next(m, reset, command_valid, command_store, command_addr, data_to_bus,
                        mem_req_ready, mem_rdata_valid, mem_rdata, mem_wdata_ready, mem_wack_valid);
        if (!reset) model_live <= 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            logic exp_rv;
            logic exp_wv;
            exp_rv = m.busy && !m.req_done;
            exp_wv = m.busy && m.req_done && m.store && (m.beats < 6'd16);
            chk("bus_valid", 64'(bus_valid), 64'(m.busy && m.pulse && !m.store));
            chk("bus_ready", 64'(bus_ready), 64'(m.busy && m.pulse && m.store));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("mem_req_addr", mem_req_addr, m.addr);
                chk("mem_req_store", 64'(mem_req_store), 64'(m.store));
            end
            chk("mem_wdata_valid", 64'(mem_wdata_valid), 64'(exp_wv));
            if (exp_wv) begin
                chk("mem_wdata", mem_wdata, m.wline[m.beats[3:0]]);
                chk("mem_wdata_last", 64'(mem_wdata_last), 64'(m.beats == 6'd15));
            end
            for (int k = 0; k < BEATS; k++)
                chk($sformatf("data_from_bus[%0d]", k), data_from_bus[k*DW +: DW], m.rline[k]);
            if (bus_valid) n_bv++;
            if (bus_ready) n_br++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] make_line(input logic [63:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = base + 64'(k);
        return l;
    endfunction

    // mode: 0 hold command until pulse, 1 drop command right after latch, 2 keep held for a follow-on
    task automatic run_load(input logic [63:0] addr, input logic [63:0] exp_addr,
                            input logic [63:0] base, input int stall, input int exp_lat, input int mode);
        int n;
        command_valid = 1'b1; command_store = 1'b0; command_addr = addr;
        mem_req_ready = 1'b0;
        step(); n = 1;
        if (mode == 1) command_valid = 1'b0;
        command_addr = ~addr;
        chk("load_req_store", 64'(mem_req_store), 64'(0));
        while (n <= stall + 1) begin
            mem_req_ready = (n == stall + 1);
            chk("load_req_valid", 64'(mem_req_valid), 64'(1));
            chk("load_req_addr", mem_req_addr, exp_addr);
            step(); n++;
        end
        mem_req_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            mem_rdata_valid = 1'b1; mem_rdata = base + 64'(k);
            step(); n++;
        end
        mem_rdata_valid = 1'b0; mem_rdata = '0;
        while (bus_valid !== 1'b1 && n < exp_lat + 20) begin step(); n++; end
        chk("load_latency", 64'(n), 64'(exp_lat));
        for (int k = 0; k < BEATS; k++)
            chk("load_line", data_from_bus[k*DW +: DW], base + 64'(k));
        if (mode != 2) command_valid = 1'b0;
        step();
        chk("bus_valid_width", 64'(bus_valid), 64'(0));
    endtask

    task automatic run_store(input logic [63:0] addr, input logic [63:0] exp_addr,
                             input logic [63:0] base, input bit toggle, input int stray, input int exp_lat);
        int n;
        int sent;
        int guard;
        bit r;
        command_valid = 1'b1; command_store = 1'b1; command_addr = addr;
        data_to_bus = make_line(base); mem_req_ready = 1'b1;
        step(); n = 1;
        chk("store_req_valid", 64'(mem_req_valid), 64'(1));
        chk("store_req_store", 64'(mem_req_store), 64'(1));
        chk("store_req_addr", mem_req_addr, exp_addr);
        command_addr = ~addr; data_to_bus = make_line(64'hFFFF_0000);
        step(); n++;
        mem_req_ready = 1'b0;
        sent = 0; guard = 0; r = 1'b1;
        while (sent < BEATS && guard < 100) begin
            mem_wdata_ready = r;
            mem_wack_valid = (n == stray);
            chk("store_beat_valid", 64'(mem_wdata_valid), 64'(1));
            if (mem_wdata_valid) begin
                chk("store_beat", mem_wdata, base + 64'(sent));
                chk("store_last", 64'(mem_wdata_last), 64'(sent == BEATS - 1));
                if (r) sent++;
            end
            step(); n++; guard++;
            if (toggle) r = ~r;
        end
        chk("store_beats_sent", 64'(sent), 64'(BEATS));
        mem_wdata_ready = 1'b0; mem_wack_valid = 1'b0;
        chk("store_wack_quiet", 64'(mem_wdata_valid), 64'(0));
        chk("store_no_early_ready", 64'(bus_ready), 64'(0));
        mem_wack_valid = 1'b1;
        step(); n++;
        mem_wack_valid = 1'b0;
        while (bus_ready !== 1'b1 && n < exp_lat + 20) begin step(); n++; end
        chk("store_latency", 64'(n), 64'(exp_lat));
        command_valid = 1'b0; command_store = 1'b0;
        step();
        chk("bus_ready_width", 64'(bus_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bv0;
        int br0;
        reset = 1'b0; command_valid = 1'b0; command_store = 1'b0; command_rready = 1'b1;
        command_addr = '0; data_to_bus = '0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
        mem_rdata = '0; mem_wdata_ready = 1'b0; mem_wack_valid = 1'b0;
        repeat (3) step();
        chk("rst_bus_valid", 64'(bus_valid), 64'(0));
        chk("rst_bus_ready", 64'(bus_ready), 64'(0));
        chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_wdata_valid", 64'(mem_wdata_valid), 64'(0));
        chk("rst_wdata_last", 64'(mem_wdata_last), 64'(0));
        chk("rst_req_addr", mem_req_addr, 64'(0));
        chk("rst_req_store", 64'(mem_req_store), 64'(0));
        chk("rst_wdata", mem_wdata, 64'(0));
        chk("rst_data_from_bus_zero", 64'(data_from_bus == '0), 64'(1));
        reset = 1'b1;
        step();

        // Zero-wait load with unaligned address
        run_load(64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEF0, 64'h100, 0, 18, 0);

        // Stray read beats while idle
        mem_rdata_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        step(); step();
        mem_rdata_valid = 1'b0; mem_rdata = '0;
        step();
        chk("stray_idle_bus_valid", 64'(bus_valid), 64'(0));
        chk("stray_idle_req_valid", 64'(mem_req_valid), 64'(0));
        for (int k = 0; k < BEATS; k++)
            chk("stray_idle_line", data_from_bus[k*DW +: DW], 64'h100 + 64'(k));

        // Store with alternating write backpressure
        run_store(64'h1000, 64'h1000, 64'hA0, 1'b1, -1, 34);

        // Zero-wait store with a stray write ack during the data phase
        run_store(64'h2008, 64'h2000, 64'hB0, 1'b0, 5, 19);
        for (int k = 0; k < BEATS; k++)
            chk("store_keeps_read_line", data_from_bus[k*DW +: DW], 64'h100 + 64'(k));

        // Request stalled five cycles, command dropped after latch
        run_load(64'h3000, 64'h3000, 64'h400, 5, 23, 1);

        // Back-to-back load then store with command_valid held
        bv0 = n_bv; br0 = n_br;
        run_load(64'h4000, 64'h4000, 64'h500, 0, 18, 2);
        run_store(64'h5000, 64'h5000, 64'hC0, 1'b0, -1, 19);
        chk("b2b_bus_valid_pulses", 64'(n_bv - bv0), 64'(1));
        chk("b2b_bus_ready_pulses", 64'(n_br - br0), 64'(1));

        // Reset after beat 7 of a load
        command_valid = 1'b1; command_store = 1'b0; command_addr = 64'h40; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0; command_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 64'h300 + 64'(k);
            step();
        end
        reset = 1'b0; mem_rdata = 64'h308;
        step();
        chk("rstmid_bus_valid", 64'(bus_valid), 64'(0));
        chk("rstmid_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rstmid_wdata_valid", 64'(mem_wdata_valid), 64'(0));
        chk("rstmid_req_addr", mem_req_addr, 64'(0));
        chk("rstmid_data_zero", 64'(data_from_bus == '0), 64'(1));
        reset = 1'b1;
        for (int k = 9; k < BEATS; k++) begin
            mem_rdata = 64'h300 + 64'(k);
            step();
        end
        mem_rdata_valid = 1'b0; mem_rdata = '0;
        step();
        chk("rstmid_no_pulse", 64'(bus_valid), 64'(0));
        chk("rstmid_dropped_beats", data_from_bus[DW-1:0], 64'(0));
        run_load(64'h80, 64'h80, 64'h200, 0, 18, 0);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_bus_bridge.md
# line_bus_bridge

Memory-side bridge directly downstream of the direct-mapped L1 caches. It accepts one whole-line command at a time from a cache's command interface (`command_valid`/`command_store`/`command_addr`/line data) and serialises it into a burst of `DATA_WIDTH`-bit beats on the memory interface. It reassembles read beats into a full line, or streams a dirty line out and waits for the write acknowledge. It returns the single-cycle `bus_valid` (load done) or `bus_ready` (store done) pulse that the cache state machine waits on.

## Interface
- `ADDR_WIDTH`, 64, address width.
- `DATA_WIDTH`, 64, beat width and cache word width.
- `OFFSET_LENGTH`, 4, log2 of beats per line; `BEATS = 2**OFFSET_LENGTH`, line = `DATA_WIDTH*BEATS` bits.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset. A value of 0 at a rising edge resets the block.
- `command_valid`  in  1  cache command pending; held until the cache sees its completion pulse.
- `command_store`  in  1  1 = write line back, 0 = fetch line.
- `command_rready`  in  1  cache ready for read data. Informational only; not used for flow control.
- `command_addr`  in  `ADDR_WIDTH`  line address. Low `OFFSET_LENGTH` bits are forced to 0 internally.
- `data_to_bus`  in  `DATA_WIDTH*BEATS`  line to write back.
- `data_from_bus`  out  `DATA_WIDTH*BEATS`  assembled read line; registered; stable while `bus_valid`=1.
- `bus_valid`  out  1  one-cycle pulse: read line complete.
- `bus_ready`  out  1  one-cycle pulse: write-back complete.
- `mem_req_valid`  out  1  burst request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_store`  out  1  burst direction.
- `mem_req_addr`  out  `ADDR_WIDTH`  line-aligned burst address.
- `mem_rdata_valid`  in  1  read beat present.
- `mem_rdata`  in  `DATA_WIDTH`  read beat.
- `mem_wdata_valid`  out  1  write beat present.
- `mem_wdata_ready`  in  1  memory accepts the write beat.
- `mem_wdata`  out  `DATA_WIDTH`  write beat.
- `mem_wdata_last`  out  1  final write beat (count = `BEATS-1`).
- `mem_wack_valid`  in  1  write burst committed.

## Operation
States and transitions:
- IDLE: if `command_valid`, latch the aligned address and `command_store`; if store, also latch `data_to_bus` into the line buffer. Then → REQ.
- REQ: `mem_req_valid`=1. When `mem_req_ready` is sampled, → WDATA (store) or RDATA (load), and the beat counter clears.
- RDATA: on each `mem_rdata_valid`, write `mem_rdata` into line-buffer slot `cnt` (beat 0 = bits `[DATA_WIDTH-1:0]`, ascending) and increment `cnt`. On the beat with `cnt==BEATS-1`, → RESP.
- WDATA: `mem_wdata_valid`=1 and `mem_wdata` = buffer slot `cnt`. When `mem_wdata_ready` is sampled, increment `cnt`. The last handshake → WACK.
- WACK: wait for `mem_wack_valid`, then → RESP.
- RESP: pulse `bus_valid` (load) or `bus_ready` (store) for exactly one cycle, then → IDLE.

Rules:
- The beat counter is `OFFSET_LENGTH` bits wide and wraps from `BEATS-1` to 0. It is reset on entry to RDATA and WDATA.
- One command in flight. `command_valid` is sampled only in IDLE. Changes to the command inputs after the IDLE latch are ignored. If `command_valid` drops mid-burst, the burst still completes and the completion pulse is still issued.
- Back-to-back commands are supported: after a RESP pulse, the block is in IDLE the next cycle and samples the cache's next command. This covers a LOADING → DIRTY_WRITEBACK switch with `command_valid` held high.
- `mem_rdata_valid` outside RDATA and `mem_wack_valid` outside WACK are ignored and discarded.
- `mem_wdata` and `mem_wdata_last` are don't-care when `mem_wdata_valid`=0. `mem_req_addr` and `mem_req_store` are don't-care when `mem_req_valid`=0.

## Timing
- Reset values: state IDLE, `cnt`=0. `bus_valid`, `bus_ready`, `mem_req_valid`, `mem_wdata_valid`, `mem_wdata_last` are all 0. `data_from_bus`, `mem_req_addr`, `mem_req_store`, `mem_wdata` are 0.
- Reset during any state aborts the transaction. No completion pulse is produced. Beats arriving afterward are dropped.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Minimum load latency, with the command latched at edge E0 and zero-wait memory:
  - REQ in cycle 1.
  - Beats at E2..E(BEATS+1).
  - `bus_valid` high in cycle BEATS+2 (18 for default parameters).
- Minimum store latency, with zero-wait memory:
  - REQ in cycle 1.
  - WDATA in cycles 2..BEATS+1.
  - WACK in cycle BEATS+2.
  - `bus_ready` in cycle BEATS+3 (19 for default parameters).
- Memory wait cycles (ready=0 or valid=0) extend the corresponding state one cycle each, with outputs held constant.

## Test plan
- Load, zero wait: `command_addr`=0x1234_5678_9ABC_DEF7 → `mem_req_addr`=0x1234_5678_9ABC_DEF0, `mem_req_store`=0. Feed beats `k`=0x100+k → `data_from_bus` slot k = 0x100+k; `bus_valid` is high for exactly one cycle, 18 cycles after the latch.
- Store with backpressure: `data_to_bus` slot k = 0xA0+k, with `mem_wdata_ready` toggled 1,0,1,0,... → beats appear in order 0xA0..0xAF, each held while stalled. `mem_wdata_last` is asserted only on 0xAF. After `mem_wack_valid`, `bus_ready` pulses once.
- Back-to-back: a load completes, then `command_store`=1 the next cycle with `command_valid` held → the second REQ has `mem_req_store`=1; only one `bus_valid` and one `bus_ready` pulse occur.
- Request stall: `mem_req_ready` held 0 for 5 cycles → `mem_req_valid`, `mem_req_addr` and `mem_req_store` stay constant for those 5 cycles; `bus_valid` is delayed by exactly 5 cycles.
- Stray traffic: `mem_rdata_valid` pulsed in IDLE and `mem_wack_valid` pulsed in WDATA → no state change, no completion pulse, and `data_from_bus` is unchanged.
- Reset mid-burst: `reset`=0 after beat 7 of a load → all outputs 0 on the next cycle; the remaining beats are ignored; a new load afterwards completes normally with fresh data.
